// File: rtl/quat_pkg.sv
// Shared types, widths and saturation limits for the Q4.12 quaternion multiplier.
// Sign-extension helper keeps the 32-bit products and 34-bit sums consistent.
package quat_pkg;

    localparam int WIDTH  = 16;
    localparam int FRAC   = 12;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = PROD_W + 2;

    localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

    // Saturation limits sign-extended to accumulator width for signed compares
    localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-WIDTH){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-WIDTH){1'b1}}, SAT_MIN};

    typedef struct packed {
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
    } quat_t;

    function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [PROD_W-1:0] x);
        ext_prod = {{(ACC_W-PROD_W){x[PROD_W-1]}}, x};
    endfunction

endpackage

// File: rtl/fx_shift_sat.sv
// Rescales a 34-bit Q8.24 sum back to Q4.12 (floor shift) and clamps it to 16 bits.
module fx_shift_sat
    import quat_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [WIDTH-1:0] o_res
);

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = i_acc >>> FRAC;

    // Clamp the shifted sum to the signed 16-bit range
    always_comb begin
        o_res = w_shifted[WIDTH-1:0];
        if (w_shifted > ACC_SAT_MAX) begin
            o_res = SAT_MAX;
        end else if (w_shifted < ACC_SAT_MIN) begin
            o_res = SAT_MIN;
        end else begin
            o_res = w_shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_quat.sv
// Two-stage pipelined Hamilton product q1 (x) q2 on Q4.12 components.
// Stage 1 holds all sixteen cross products, stage 2 the scaled, saturated result.
module mult_quat
    import quat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] w_in1,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] j_in1,
    input  logic [WIDTH-1:0] k_in1,
    input  logic [WIDTH-1:0] w_in2,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] j_in2,
    input  logic [WIDTH-1:0] k_in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] w_out,
    output logic [WIDTH-1:0] i_out,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out
);

    logic signed [WIDTH-1:0]  w_c1 [4];
    logic signed [WIDTH-1:0]  w_c2 [4];
    logic signed [PROD_W-1:0] r_prod [4][4];
    logic                     r_valid1;
    logic signed [ACC_W-1:0]  w_sum [4];
    logic        [WIDTH-1:0]  w_sat [4];
    quat_t                    r_out;
    logic                     r_out_valid;

    assign w_c1[0] = w_in1;
    assign w_c1[1] = i_in1;
    assign w_c1[2] = j_in1;
    assign w_c1[3] = k_in1;
    assign w_c2[0] = w_in2;
    assign w_c2[1] = i_in2;
    assign w_c2[2] = j_in2;
    assign w_c2[3] = k_in2;

    // Stage 1: every q1 component times every q2 component, plus the valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    r_prod[a][b] <= '0;
                end
            end
        end else begin
            r_valid1 <= in_valid;
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    r_prod[a][b] <= PROD_W'(w_c1[a]) * PROD_W'(w_c2[b]);
                end
            end
        end
    end

    // Index [a][b] is q1 component a times q2 component b, order w,i,j,k
    assign w_sum[0] = ext_prod(r_prod[0][0]) - ext_prod(r_prod[1][1])
                    - ext_prod(r_prod[2][2]) - ext_prod(r_prod[3][3]);
    assign w_sum[1] = ext_prod(r_prod[0][1]) + ext_prod(r_prod[1][0])
                    + ext_prod(r_prod[2][3]) - ext_prod(r_prod[3][2]);
    assign w_sum[2] = ext_prod(r_prod[0][2]) - ext_prod(r_prod[1][3])
                    + ext_prod(r_prod[2][0]) + ext_prod(r_prod[3][1]);
    assign w_sum[3] = ext_prod(r_prod[0][3]) + ext_prod(r_prod[1][2])
                    - ext_prod(r_prod[2][1]) + ext_prod(r_prod[3][0]);

    for (genvar g = 0; g < 4; g++) begin : g_sat
        fx_shift_sat u_sat (
            .i_acc (w_sum[g]),
            .o_res (w_sat[g])
        );
    end

    // Stage 2: register the saturated components and the output valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out.w     <= w_sat[0];
            r_out.i     <= w_sat[1];
            r_out.j     <= w_sat[2];
            r_out.k     <= w_sat[3];
            r_out_valid <= r_valid1;
        end
    end

    assign out_valid = r_out_valid;
    assign w_out     = r_out.w;
    assign i_out     = r_out.i;
    assign j_out     = r_out.j;
    assign k_out     = r_out.k;

endmodule

// File: tb/tb_mult_quat.sv
// Self-checking bench for mult_quat: directed table, streaming/reset sequence,
// and randomized traffic against an integer-arithmetic Hamilton product model.
module tb_mult_quat;

    typedef logic [3:0][15:0] q_t;

    typedef struct {
        q_t    q1;
        q_t    q2;
        q_t    exp;
        string name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] w_in1 = 16'h0, i_in1 = 16'h0, j_in1 = 16'h0, k_in1 = 16'h0;
    logic [15:0] w_in2 = 16'h0, i_in2 = 16'h0, j_in2 = 16'h0, k_in2 = 16'h0;
    logic        out_valid;
    logic [15:0] w_out, i_out, j_out, k_out;

    int n_tests = 0;
    int n_fail  = 0;

    mult_quat dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .w_in1(w_in1), .i_in1(i_in1), .j_in1(j_in1), .k_in1(k_in1),
        .w_in2(w_in2), .i_in2(i_in2), .j_in2(j_in2), .k_in2(k_in2),
        .out_valid(out_valid),
        .w_out(w_out), .i_out(i_out), .j_out(j_out), .k_out(k_out)
    );

    always #5 clk = ~clk;

    function automatic q_t mk(input logic [15:0] w, input logic [15:0] i,
                              input logic [15:0] j, input logic [15:0] k);
        mk = {k, j, i, w};
    endfunction

    function automatic logic [15:0] clamp(input longint s);
        longint t;
        t = s >>> 12;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        clamp = t[15:0];
    endfunction

    // Reference Hamilton product from the textbook formulas on plain integers
    function automatic q_t model(input q_t p, input q_t q);
        longint a1, b1, c1, d1, a2, b2, c2, d2;
        a1 = longint'($signed(p[0])); b1 = longint'($signed(p[1]));
        c1 = longint'($signed(p[2])); d1 = longint'($signed(p[3]));
        a2 = longint'($signed(q[0])); b2 = longint'($signed(q[1]));
        c2 = longint'($signed(q[2])); d2 = longint'($signed(q[3]));
        model = mk(clamp(a1*a2 - b1*b2 - c1*c2 - d1*d2),
                   clamp(a1*b2 + b1*a2 + c1*d2 - d1*c2),
                   clamp(a1*c2 - b1*d2 + c1*a2 + d1*b2),
                   clamp(a1*d2 + b1*c2 - c1*b2 + d1*a2));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input q_t e);
        chk({name, ".valid"}, {15'h0, out_valid}, {15'h0, v});
        chk({name, ".w"}, w_out, e[0]);
        chk({name, ".i"}, i_out, e[1]);
        chk({name, ".j"}, j_out, e[2]);
        chk({name, ".k"}, k_out, e[3]);
    endtask

    task automatic drive(input q_t a, input q_t b, input logic v);
        w_in1 = a[0]; i_in1 = a[1]; j_in1 = a[2]; k_in1 = a[3];
        w_in2 = b[0]; i_in2 = b[1]; j_in2 = b[2]; k_in2 = b[3];
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_comp();
        if ($urandom_range(0, 3) == 0) rnd_comp = 16'($urandom);
        else rnd_comp = 16'($urandom_range(0, 16'h3000) - 16'h1800);
    endfunction

    function automatic q_t rnd_q();
        rnd_q = mk(rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp());
    endfunction

    vec_t tbl[6];
    q_t   sv_q1[5];
    q_t   sv_q2[5];
    q_t   zero_q;
    q_t   prev_q1, prev_q2;
    logic prev_v;

    initial begin
        zero_q = mk(16'h0, 16'h0, 16'h0, 16'h0);
        tbl[0] = '{mk(16'h0519, 16'h0519, 16'h0519, 16'h0519), mk(16'h0519, 16'h0519, 16'h0519, 16'h0519),
                   mk(16'hFCC0, 16'h033F, 16'h033F, 16'h033F), "same0519"};
        tbl[1] = '{mk(16'h0519, 16'h0519, 16'h0519, 16'h0519), mk(16'h02A0, 16'h02A0, 16'h02A0, 16'h02A0),
                   mk(16'hFE53, 16'h01AC, 16'h01AC, 16'h01AC), "mixed"};
        tbl[2] = '{mk(16'h1000, 16'h0000, 16'h0000, 16'h0000), mk(16'h0123, 16'hFF00, 16'h0456, 16'h8001),
                   mk(16'h0123, 16'hFF00, 16'h0456, 16'h8001), "identity"};
        tbl[3] = '{mk(16'h0000, 16'h1000, 16'h0000, 16'h0000), mk(16'h0000, 16'h0000, 16'h1000, 16'h0000),
                   mk(16'h0000, 16'h0000, 16'h0000, 16'h1000), "i_x_j"};
        tbl[4] = '{mk(16'h0000, 16'h0000, 16'h1000, 16'h0000), mk(16'h0000, 16'h1000, 16'h0000, 16'h0000),
                   mk(16'h0000, 16'h0000, 16'h0000, 16'hF000), "j_x_i"};
        tbl[5] = '{mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                   mk(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF), "saturate"};

        // Reset state
        drive(zero_q, zero_q, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, zero_q);
        rst = 1'b0;
        drive(zero_q, zero_q, 1'b0);
        tick();
        tick();

        // Directed table: single in_valid pulse, exact two-cycle latency
        for (int n = 0; n < 6; n++) begin
            drive(tbl[n].q1, tbl[n].q2, 1'b1);
            tick();
            drive(zero_q, zero_q, 1'b0);
            chk({tbl[n].name, ".early_valid"}, {15'h0, out_valid}, 16'h0);
            tick();
            chk_out(tbl[n].name, 1'b1, tbl[n].exp);
            tick();
            chk({tbl[n].name, ".valid_drop"}, {15'h0, out_valid}, 16'h0);
        end

        // Streaming with reset arriving the cycle after the third vector
        for (int n = 0; n < 5; n++) begin
            sv_q1[n] = rnd_q();
            sv_q2[n] = rnd_q();
        end
        drive(sv_q1[0], sv_q2[0], 1'b1);
        tick();
        drive(sv_q1[1], sv_q2[1], 1'b1);
        tick();
        chk_out("stream.v1", 1'b1, model(sv_q1[0], sv_q2[0]));
        drive(sv_q1[2], sv_q2[2], 1'b1);
        tick();
        chk_out("stream.v2", 1'b1, model(sv_q1[1], sv_q2[1]));
        drive(sv_q1[3], sv_q2[3], 1'b1);
        rst = 1'b1;
        tick();
        chk_out("stream.rst0", 1'b0, zero_q);
        drive(sv_q1[4], sv_q2[4], 1'b1);
        tick();
        chk_out("stream.rst1", 1'b0, zero_q);
        rst = 1'b0;
        drive(zero_q, zero_q, 1'b0);
        tick();
        chk_out("stream.post0", 1'b0, zero_q);
        tick();
        chk_out("stream.post1", 1'b0, zero_q);

        // Random traffic: output after each edge reflects the inputs one edge earlier
        prev_v  = 1'b0;
        prev_q1 = zero_q;
        prev_q2 = zero_q;
        for (int t = 0; t < 80; t++) begin
            q_t a, b;
            logic v;
            a = rnd_q();
            b = rnd_q();
            v = 1'($urandom_range(0, 1));
            drive(a, b, v);
            tick();
            if (t >= 1) chk_out("random", prev_v, model(prev_q1, prev_q2));
            prev_q1 = a;
            prev_q2 = b;
            prev_v  = v;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
